// File: rtl/apb_pkg.sv
// apb_pkg: shared types and sizing helpers for the APB master and the slave
// decoder (also intended for the future APB interconnect).
//   apb_state_e : master FSM states
//   sel_w()     : width of the slave index field, minimum 1
//   cnt_w()     : width of the wait-state counter for a given timeout
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } apb_state_e;

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_w(input int t);
    return (t <= 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// apb_slave_decode: combinational slave-select decoder.
//   sel_bits_i : top SEL_W address bits
//   idx_o      : slave index (forced to 0 with a single slave)
//   onehot_o   : one-hot PSEL vector, all zero when idx is out of range
//   valid_o    : idx addresses an existing slave
module apb_slave_decode
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = sel_w(NUM_SLAVES)
) (
  input  logic [SEL_W-1:0]      sel_bits_i,
  output logic [SEL_W-1:0]      idx_o,
  output logic [NUM_SLAVES-1:0] onehot_o,
  output logic                  valid_o
);

  assign idx_o   = (NUM_SLAVES == 1) ? '0 : sel_bits_i;
  assign valid_o = (int'(idx_o) < NUM_SLAVES);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (int'(idx_o) == i) onehot_o[i] = 1'b1;
  end

endmodule

// File: rtl/apb_master_param.sv
// apb_master_param: parametrised APB4 master with NUM_SLAVES decoded selects.
//   PCLK / PRESERn           : clock, synchronous active-low reset
//   cmd_*                    : valid/ready command port (write, addr, wdata, strb)
//   rsp_*                    : one-cycle completion pulse with rdata/err/timeout
//   paddr..penable           : registered APB request outputs
//   pready/prdata/pslverr    : per-slave APB responses, only idx is looked at
// Every output is a flop except cmd_ready, which also opens in the cycle an
// ACCESS completes so the next command can start back-to-back.
module apb_master_param
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESERn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  input  logic [DATA_W/8-1:0]          cmd_strb,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W/8-1:0]          pstrb,
  output logic                         pwrite,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int SEL_W  = sel_w(NUM_SLAVES);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_w(TIMEOUT);

  apb_state_e              state_q, state_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       paddr_q, paddr_d;
  logic [DATA_W-1:0]       pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic                    pwrite_q, pwrite_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  logic [SEL_W-1:0]        dec_idx;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    dec_valid;

  apb_slave_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_dec (
    .sel_bits_i (cmd_addr[ADDR_W-1 -: SEL_W]),
    .idx_o      (dec_idx),
    .onehot_o   (dec_onehot),
    .valid_o    (dec_valid)
  );

  // Response lines of the slave currently addressed.
  logic              pready_s, pslverr_s;
  logic [DATA_W-1:0] prdata_s;

  always_comb begin
    pready_s  = 1'b0;
    pslverr_s = 1'b0;
    prdata_s  = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (int'(idx_q) == i) begin
        pready_s  = pready[i];
        pslverr_s = pslverr[i];
        prdata_s  = prdata[i*DATA_W +: DATA_W];
      end
  end

  logic timeout_hit, done, accept;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT)) && !pready_s;
  assign done        = (state_q == ACCESS) && (pready_s || timeout_hit);
  assign cmd_ready   = (state_q == IDLE) || done;
  assign accept      = cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;

    unique case (state_q)
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = CNT_W'(1);
      end
      ACCESS: begin
        if (done) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = timeout_hit || pslverr_s;
          rsp_timeout_d = timeout_hit;
          if (!pwrite_q && !timeout_hit && !pslverr_s) rsp_rdata_d = prdata_s;
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
        end else if (cnt_q != '1) begin
          // saturate so TIMEOUT = 0 can wait forever without wrapping
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = IDLE;
      end
      default: ;
    endcase

    // A new command overrides the IDLE fall-through of a completing ACCESS.
    if (accept) begin
      idx_d     = dec_idx;
      paddr_d   = cmd_addr;
      pwdata_d  = cmd_wdata;
      pstrb_d   = cmd_write ? cmd_strb : '0;
      pwrite_d  = cmd_write;
      penable_d = 1'b0;
      if (dec_valid) begin
        state_d = SETUP;
        psel_d  = dec_onehot;
      end else begin
        state_d = DERR;
        psel_d  = '0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERn) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pwrite      = pwrite_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_param.sv
// Bench for apb_master_param: dut0 uses the default parameters, dut1 has
// three slaves and a short timeout for the decode-error and abort cases.
module tb_apb_master_param;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic       PRESERn;
  logic       cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic [0:0] cmd_strb;

  logic        cmd_valid0, cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0, pwrite0, penable0;
  logic [7:0]  rsp_rdata0, paddr0, pwdata0;
  logic [0:0]  pstrb0;
  logic [3:0]  psel0, pready0, pslverr0;
  logic [31:0] prdata0;

  logic        cmd_valid1, cmd_ready1, rsp_valid1, rsp_err1, rsp_timeout1, pwrite1, penable1;
  logic [7:0]  rsp_rdata1, paddr1, pwdata1;
  logic [0:0]  pstrb1;
  logic [2:0]  psel1, pready1, pslverr1;
  logic [23:0] prdata1;

  apb_master_param #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(4), .TIMEOUT(16)) dut0 (
    .PCLK(PCLK), .PRESERn(PRESERn),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .rsp_timeout(rsp_timeout0), .paddr(paddr0), .pwdata(pwdata0), .pstrb(pstrb0),
    .pwrite(pwrite0), .psel(psel0), .penable(penable0), .pready(pready0),
    .prdata(prdata0), .pslverr(pslverr0)
  );

  apb_master_param #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT(4)) dut1 (
    .PCLK(PCLK), .PRESERn(PRESERn),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .rsp_timeout(rsp_timeout1), .paddr(paddr1), .pwdata(pwdata1), .pstrb(pstrb1),
    .pwrite(pwrite1), .psel(psel1), .penable(penable1), .pready(pready1),
    .prdata(prdata1), .pslverr(pslverr1)
  );

  // One command plus the slave behaviour it should meet and the response it
  // should produce (e_lat = cycles from accept to rsp_valid).
  typedef struct {
    bit       w;
    bit [7:0] addr;
    bit [7:0] wdata;
    bit       strb;
    int       waits;
    bit       err;
    bit [7:0] rd;
    bit [7:0] e_rdata;
    bit       e_err;
    bit       e_to;
    int       e_lat;
  } vec_t;

  typedef struct {
    int       cyc;
    bit [7:0] rdata;
    bit       err;
    bit       to;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   bg_en  = 1'b0;
  vec_t cur;
  exp_t expq[$];
  vec_t planq[$];

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Transaction-level reference: response follows from wait count and error.
  function automatic vec_t model(input vec_t v);
    bit tmo;
    tmo       = (v.waits >= 16);
    v.e_err   = tmo || v.err;
    v.e_to    = tmo;
    v.e_lat   = tmo ? (2 + 16) : (3 + v.waits);
    v.e_rdata = (!v.w && !v.e_err) ? v.rd : 8'h00;
    return v;
  endfunction

  // Response monitor for dut0: expected responses queued at accept.
  always @(negedge PCLK) begin
    if (bg_en) begin
      if (rsp_valid0) begin
        if (expq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          exp_t e;
          e = expq.pop_front();
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_rdata", rsp_rdata0, e.rdata);
          chk("rsp_err", rsp_err0, e.err);
          chk("rsp_timeout", rsp_timeout0, e.to);
        end
      end
      if (expq.size() != 0 && expq[0].cyc < cyc) begin
        void'(expq.pop_front());
        chk("rsp_missing", 0, 1);
      end
      if (cmd_valid0 && cmd_ready0) begin
        expq.push_back('{cyc + cur.e_lat, cur.e_rdata, cur.e_err, cur.e_to});
        planq.push_back(cur);
      end
    end
  end

  // APB slave model for dut0: random noise on every unselected slave, the
  // planned wait states / error / data on the selected one.
  vec_t rp;
  bit   have_rp = 1'b0;
  int   wcnt = 0;
  int   ridx = 0;

  initial forever begin
    tick();
    if (bg_en) begin
      pready0  = 4'($urandom);
      pslverr0 = 4'($urandom);
      prdata0  = $urandom;
      if (psel0 != 0 && !penable0) begin
        if (planq.size() == 0) begin
          chk("plan_missing", 0, 1);
          have_rp = 1'b0;
        end else begin
          rp      = planq.pop_front();
          have_rp = 1'b1;
          wcnt    = rp.waits;
        end
      end
      if (have_rp && psel0 != 0) begin
        ridx = int'(rp.addr[7:6]);
        chk("bus_psel", psel0, 4'b0001 << ridx);
        chk("bus_paddr", paddr0, rp.addr);
        chk("bus_pwrite", pwrite0, rp.w);
        chk("bus_pstrb", pstrb0, rp.w ? rp.strb : 1'b0);
        if (rp.w) chk("bus_pwdata", pwdata0, rp.wdata);
        if (penable0) begin
          pready0[ridx] = (wcnt == 0);
          if (wcnt == 0) begin
            pslverr0[ridx]          = rp.err;
            prdata0[ridx*8 +: 8]    = rp.rd;
          end
          wcnt--;
        end
      end
    end
  end

  task automatic send(input vec_t v);
    bit ok;
    ok         = 1'b0;
    cur        = v;
    cmd_write  = v.w;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    cmd_strb   = v.strb;
    cmd_valid0 = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge PCLK);
      if (cmd_ready0) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    tick();
    cmd_valid0 = 1'b0;
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    // w, addr, wdata, strb, waits, err, rd, e_rdata, e_err, e_to, e_lat
    tbl[0] = '{1'b1, 8'h12, 8'h5A, 1'b1, 0,  1'b0, 8'h99, 8'h00, 1'b0, 1'b0, 3};
    tbl[1] = '{1'b0, 8'h85, 8'h00, 1'b1, 2,  1'b0, 8'hC3, 8'hC3, 1'b0, 1'b0, 5};
    tbl[2] = '{1'b0, 8'h40, 8'h00, 1'b0, 0,  1'b1, 8'h55, 8'h00, 1'b1, 1'b0, 3};
    tbl[3] = '{1'b1, 8'hC8, 8'h11, 1'b0, 1,  1'b1, 8'h66, 8'h00, 1'b1, 1'b0, 4};
    tbl[4] = '{1'b0, 8'hFF, 8'h00, 1'b0, 16, 1'b0, 8'h42, 8'h00, 1'b1, 1'b1, 18};
    tbl[5] = '{1'b0, 8'h3C, 8'h00, 1'b0, 15, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 18};
    tbl[6] = '{1'b1, 8'h7E, 8'hE7, 1'b1, 3,  1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 6};

    PRESERn = 1'b0;
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    pready0 = '0; pslverr0 = '0; prdata0 = '0;
    pready1 = '0; pslverr1 = '0; prdata1 = '0;
    repeat (3) tick();

    chk("rst_psel", psel0, 0);
    chk("rst_penable", penable0, 0);
    chk("rst_paddr", paddr0, 0);
    chk("rst_rsp_valid", rsp_valid0, 0);
    chk("rst_cmd_ready", cmd_ready0, 1);
    PRESERn = 1'b1;
    tick();

    // Table vectors, issued back-to-back, then random traffic.
    bg_en = 1'b1;
    foreach (tbl[i]) send(tbl[i]);
    for (int n = 0; n < 60; n++) begin
      rv.w     = 1'($urandom);
      rv.addr  = 8'($urandom);
      rv.wdata = 8'($urandom);
      rv.strb  = 1'($urandom);
      rv.waits = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20))
                                             : int'($urandom_range(0, 3));
      rv.err   = ($urandom_range(0, 3) == 0);
      rv.rd    = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      send(model(rv));
    end
    for (int k = 0; k < 100 && expq.size() != 0; k++) tick();
    chk("drain_empty", expq.size(), 0);
    bg_en = 1'b0;
    pready0 = 4'b0001; pslverr0 = 4'b1110; prdata0 = 32'h12345678;
    tick();

    // Write 0x5A to 0x12, zero wait states, cycle by cycle.
    cmd_write = 1'b1; cmd_addr = 8'h12; cmd_wdata = 8'h5A; cmd_strb = 1'b1;
    cmd_valid0 = 1'b1;
    #1 chk("w_ready", cmd_ready0, 1);
    tick(); cmd_valid0 = 1'b0;
    chk("w_setup_psel", psel0, 4'b0001);
    chk("w_setup_pen", penable0, 0);
    chk("w_setup_pstrb", pstrb0, 1);
    chk("w_setup_pwdata", pwdata0, 8'h5A);
    tick();
    chk("w_acc_psel", psel0, 4'b0001);
    chk("w_acc_pen", penable0, 1);
    chk("w_acc_rsp", rsp_valid0, 0);
    tick();
    chk("w_rsp_valid", rsp_valid0, 1);
    chk("w_rsp_err", rsp_err0, 0);
    chk("w_rsp_rdata", rsp_rdata0, 0);
    chk("w_end_psel", psel0, 0);
    tick();
    chk("w_rsp_pulse", rsp_valid0, 0);

    // Back-to-back: write 0x10 then read 0x50 held valid.
    pready0 = 4'b1111; pslverr0 = 4'b0000; prdata0 = 32'hDDCCBBAA;
    cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'h21; cmd_valid0 = 1'b1;
    tick();
    chk("b2b_setup1_psel", psel0, 4'b0001);
    cmd_write = 1'b0; cmd_addr = 8'h50;
    #1 chk("b2b_ready_setup", cmd_ready0, 0);
    tick();
    chk("b2b_acc1_pen", penable0, 1);
    chk("b2b_ready_done", cmd_ready0, 1);
    tick(); cmd_valid0 = 1'b0;
    chk("b2b_setup2_psel", psel0, 4'b0010);
    chk("b2b_setup2_pen", penable0, 0);
    chk("b2b_rsp1", rsp_valid0, 1);
    chk("b2b_paddr2", paddr0, 8'h50);
    tick();
    chk("b2b_acc2_pen", penable0, 1);
    chk("b2b_gap", rsp_valid0, 0);
    tick();
    chk("b2b_rsp2", rsp_valid0, 1);
    chk("b2b_rdata2", rsp_rdata0, 8'hBB);

    // Decode error on the three-slave instance.
    cmd_write = 1'b0; cmd_addr = 8'hC0; cmd_valid1 = 1'b1;
    #1 chk("derr_ready", cmd_ready1, 1);
    tick(); cmd_valid1 = 1'b0;
    chk("derr_psel", psel1, 0);
    chk("derr_busy", cmd_ready1, 0);
    chk("derr_early", rsp_valid1, 0);
    tick();
    chk("derr_rsp", rsp_valid1, 1);
    chk("derr_err", rsp_err1, 1);
    chk("derr_to", rsp_timeout1, 0);
    chk("derr_rdata", rsp_rdata1, 0);
    chk("derr_psel2", psel1, 0);
    tick();
    chk("derr_pulse", rsp_valid1, 0);

    // Timeout: slave1 never ready (other slaves ready, must be ignored).
    pready1 = 3'b101; prdata1 = 24'hFFFFFF;
    cmd_addr = 8'h40; cmd_valid1 = 1'b1;
    tick(); cmd_valid1 = 1'b0;
    chk("to_setup_psel", psel1, 3'b010);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("to_acc_pen", penable1, 1);
      chk("to_acc_psel", psel1, 3'b010);
      chk("to_acc_rsp", rsp_valid1, 0);
    end
    tick();
    chk("to_psel_drop", psel1, 0);
    chk("to_pen_drop", penable1, 0);
    chk("to_rsp", rsp_valid1, 1);
    chk("to_err", rsp_err1, 1);
    chk("to_flag", rsp_timeout1, 1);
    chk("to_rdata", rsp_rdata1, 0);

    // Reset during a stalled slave3 read with pslverr pending.
    pready0 = 4'b0000; pslverr0 = 4'b1000;
    cmd_write = 1'b0; cmd_addr = 8'hC4; cmd_valid0 = 1'b1;
    tick(); cmd_valid0 = 1'b0;
    chk("rst_setup_psel", psel0, 4'b1000);
    tick();
    chk("rst_acc_pen", penable0, 1);
    tick();
    PRESERn = 1'b0;
    tick();
    chk("mrst_psel", psel0, 0);
    chk("mrst_pen", penable0, 0);
    chk("mrst_paddr", paddr0, 0);
    chk("mrst_pwrite", pwrite0, 0);
    chk("mrst_rsp", rsp_valid0, 0);
    chk("mrst_err", rsp_err0, 0);
    chk("mrst_idle", cmd_ready0, 1);
    PRESERn = 1'b1;
    pready0 = 4'b1000; pslverr0 = 4'b0000; prdata0 = 32'h77000000;
    tick();
    chk("mrst_no_rsp", rsp_valid0, 0);
    cmd_valid0 = 1'b1;
    tick(); cmd_valid0 = 1'b0;
    tick();
    tick();
    chk("post_rst_rsp", rsp_valid0, 1);
    chk("post_rst_rdata", rsp_rdata0, 8'h77);
    chk("post_rst_err", rsp_err0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
